instr_fetch_unit: RTL and testbench

Fetch stage directly downstream of the program counter. It consumes the current PC and issues a read to instruction memory over a valid/ready request channel. It accepts the response, then presents the instruction and its PC to the decoder over a valid/ready channel. It also drives the PC increment strobe and handles branch flushes, including discarding in-flight responses.

---
 rtl/instr_fetch_unit_pkg.sv | 20 ++
 rtl/instr_fetch_unit.sv | 85 ++++++++
 tb/tb_instr_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage and its neighbours (decoder and PC wrappers).
// Holds the fetch FSM encoding and the default datapath widths.
package instr_fetch_unit_pkg;

  localparam int ADDR_W_DFLT  = 16;
  localparam int INSTR_W_DFLT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  // Where the FSM goes once the current fetch is finished or abandoned.
  function automatic fetch_state_e resume_state_f(input logic en);
    return en ? REQ : IDLE;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one memory read per PC value, captures the response and hands
// the instruction with its address to the decoder; branch flushes discard in-flight work.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DFLT,
  parameter int INSTR_W = INSTR_W_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_inc,
  input  logic               flush,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_rsp_valid,
  input  logic [INSTR_W-1:0] mem_rsp_data,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir_data,
  output logic [ADDR_W-1:0]  ir_pc
);

  fetch_state_e      state;
  fetch_state_e      resume_state;
  logic              discard;
  logic [ADDR_W-1:0] fetch_pc;
  logic              req_hs;
  logic              ir_hs;

  // A flush cycle never issues or presents anything: the PC is reloading on this edge.
  assign mem_req_valid = (state == REQ) && !flush;
  assign mem_req_addr  = pc;
  assign req_hs        = mem_req_valid && mem_req_ready;
  assign pc_inc        = req_hs;
  assign ir_valid      = (state == HOLD) && !flush;
  assign ir_hs         = ir_valid && ir_ready;
  assign resume_state  = resume_state_f(en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      discard  <= 1'b0;
      fetch_pc <= '0;
      ir_data  <= '0;
      ir_pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && !flush) state <= REQ;
        end
        REQ: begin
          if (req_hs) begin
            state    <= WAIT;
            fetch_pc <= pc;
            discard  <= 1'b0;
          end else if (!flush && !en) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          // The response to a flushed fetch still arrives and must be swallowed.
          if (mem_rsp_valid) begin
            if (discard || flush) begin
              state <= resume_state;
            end else begin
              ir_data <= mem_rsp_data;
              ir_pc   <= fetch_pc;
              state   <= HOLD;
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        HOLD: begin
          if (flush || ir_hs) state <= resume_state;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios plus a randomized run checked
// against a transaction-level scoreboard of outstanding and held fetches.
module tb_instr_fetch_unit;

  localparam int AW = 16;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] flush_tgt = '0;
  logic [AW-1:0] pc = '0;
  logic [AW-1:0] pc_init = '0;
  logic          pc_inc;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid = 1'b0;
  logic [IW-1:0] mem_rsp_data = '0;
  logic          ir_valid;
  logic          ir_ready = 1'b0;
  logic [IW-1:0] ir_data;
  logic [AW-1:0] ir_pc;

  int            n_cmp = 0;
  int            n_err = 0;
  int            rsp_delay = 1;
  bit            use_fixed = 1'b0;
  logic [IW-1:0] fixed_data = '0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .pc_inc(pc_inc), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_pc(ir_pc)
  );

  function automatic logic [IW-1:0] memval(input logic [AW-1:0] a);
    logic [IW-1:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h5A5A;
  endfunction

  // Program counter: flush loads the target, otherwise pc_inc advances it.
  always @(posedge clk) begin : pc_model
    logic r, f, inc;
    logic [AW-1:0] t;
    r = rst; f = flush; inc = pc_inc; t = flush_tgt;
    #1;
    if (r) pc = pc_init;
    else if (f) pc = t;
    else if (inc) pc = pc + 16'd1;
  end

  // Instruction memory: one response per accepted request, rsp_delay cycles later.
  int            mem_cnt = 0;
  logic [IW-1:0] mem_buf = '0;
  always @(posedge clk) begin : mem_model
    logic r, hs;
    logic [AW-1:0] a;
    int dly;
    r = rst; hs = mem_req_valid && mem_req_ready; a = mem_req_addr; dly = rsp_delay;
    #1;
    mem_rsp_valid = 1'b0;
    if (r) begin
      mem_cnt = 0;
    end else begin
      if (hs) begin
        mem_cnt = dly;
        mem_buf = use_fixed ? fixed_data : memval(a);
      end
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = mem_buf;
        end
      end
    end
  end

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [AW-1:0] start_pc);
    rst = 1'b1; en = 1'b0; flush = 1'b0; flush_tgt = '0; mem_req_ready = 1'b0;
    ir_ready = 1'b0; use_fixed = 1'b0; rsp_delay = 1; pc_init = start_pc;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mem_req_ready = 1'b1; ir_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b want 0", mem_req_valid); end
    n_cmp++; if (pc_inc !== 1'b0) begin n_err++; $display("FAIL rst_pc_inc: got %b want 0", pc_inc); end
    n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL rst_ir_valid: got %b want 0", ir_valid); end
    n_cmp++; if (ir_data !== 16'h0000) begin n_err++; $display("FAIL rst_ir_data: got %h want 0000", ir_data); end
    n_cmp++; if (ir_pc !== 16'h0000) begin n_err++; $display("FAIL rst_ir_pc: got %h want 0000", ir_pc); end
  endtask

  task automatic test_basic();
    do_reset(16'h0000);
    en = 1'b1; mem_req_ready = 1'b1; ir_ready = 1'b1; use_fixed = 1'b1; fixed_data = 16'hA5A5;
    @(negedge clk);
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL basic_c0_req: got %b want 0", mem_req_valid); end
    step_cycle(); @(negedge clk);
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL basic_c1_req: got %b want 1", mem_req_valid); end
    n_cmp++; if (mem_req_addr !== 16'h0000) begin n_err++; $display("FAIL basic_c1_addr: got %h want 0000", mem_req_addr); end
    n_cmp++; if (pc_inc !== 1'b1) begin n_err++; $display("FAIL basic_c1_inc: got %b want 1", pc_inc); end
    step_cycle(); @(negedge clk);
    n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL basic_c2_irv: got %b want 0", ir_valid); end
    step_cycle(); @(negedge clk);
    n_cmp++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL basic_c3_irv: got %b want 1", ir_valid); end
    n_cmp++; if (ir_data !== 16'hA5A5) begin n_err++; $display("FAIL basic_c3_data: got %h want a5a5", ir_data); end
    n_cmp++; if (ir_pc !== 16'h0000) begin n_err++; $display("FAIL basic_c3_pc: got %h want 0000", ir_pc); end
    step_cycle(); @(negedge clk);
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL basic_c4_req: got %b want 1", mem_req_valid); end
    n_cmp++; if (mem_req_addr !== 16'h0001) begin n_err++; $display("FAIL basic_c4_addr: got %h want 0001", mem_req_addr); end
    en = 1'b0;
  endtask

  task automatic test_req_stall();
    int incs;
    do_reset(16'h0010);
    en = 1'b1; ir_ready = 1'b1;
    incs = 0;
    @(negedge clk); incs += int'(pc_inc);
    for (int i = 1; i <= 4; i++) begin
      step_cycle(); @(negedge clk);
      incs += int'(pc_inc);
      n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL stall_req_valid c%0d: got %b want 1", i, mem_req_valid); end
      n_cmp++; if (mem_req_addr !== 16'h0010) begin n_err++; $display("FAIL stall_addr c%0d: got %h want 0010", i, mem_req_addr); end
      n_cmp++; if (pc_inc !== 1'b0) begin n_err++; $display("FAIL stall_inc c%0d: got %b want 0", i, pc_inc); end
    end
    step_cycle(); mem_req_ready = 1'b1; @(negedge clk);
    incs += int'(pc_inc);
    n_cmp++; if (pc_inc !== 1'b1) begin n_err++; $display("FAIL stall_accept_inc: got %b want 1", pc_inc); end
    n_cmp++; if (mem_req_addr !== 16'h0010) begin n_err++; $display("FAIL stall_accept_addr: got %h want 0010", mem_req_addr); end
    step_cycle(); mem_req_ready = 1'b0; @(negedge clk); incs += int'(pc_inc);
    step_cycle(); @(negedge clk); incs += int'(pc_inc);
    n_cmp++; if (ir_data !== memval(16'h0010)) begin n_err++; $display("FAIL stall_ir_data: got %h want %h", ir_data, memval(16'h0010)); end
    n_cmp++; if (ir_pc !== 16'h0010) begin n_err++; $display("FAIL stall_ir_pc: got %h want 0010", ir_pc); end
    n_cmp++; if (incs != 1) begin n_err++; $display("FAIL stall_inc_count: got %0d want 1", incs); end
    en = 1'b0;
  endtask

  task automatic test_flush_wait();
    do_reset(16'h0020);
    en = 1'b1; mem_req_ready = 1'b1; ir_ready = 1'b1; use_fixed = 1'b1; fixed_data = 16'h1111;
    rsp_delay = 3;
    @(negedge clk);
    step_cycle(); @(negedge clk);
    n_cmp++; if (pc_inc !== 1'b1) begin n_err++; $display("FAIL fw_c1_inc: got %b want 1", pc_inc); end
    step_cycle(); flush = 1'b1; flush_tgt = 16'h0040; @(negedge clk);
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL fw_flush_req: got %b want 0", mem_req_valid); end
    n_cmp++; if (pc_inc !== 1'b0) begin n_err++; $display("FAIL fw_flush_inc: got %b want 0", pc_inc); end
    step_cycle(); flush = 1'b0;
    for (int c = 3; c <= 8; c++) begin
      if (c > 3) step_cycle();
      @(negedge clk);
      n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL fw_irv c%0d: got %b want 0", c, ir_valid); end
      if (c == 5) begin
        n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL fw_refetch_req: got %b want 1", mem_req_valid); end
        n_cmp++; if (mem_req_addr !== 16'h0040) begin n_err++; $display("FAIL fw_refetch_addr: got %h want 0040", mem_req_addr); end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_ir_stall();
    do_reset(16'h0030);
    en = 1'b1; mem_req_ready = 1'b1;
    @(negedge clk); step_cycle(); @(negedge clk); step_cycle(); @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      step_cycle(); @(negedge clk);
      n_cmp++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL irs_valid %0d: got %b want 1", i, ir_valid); end
      n_cmp++; if (ir_data !== memval(16'h0030)) begin n_err++; $display("FAIL irs_data %0d: got %h want %h", i, ir_data, memval(16'h0030)); end
      n_cmp++; if (ir_pc !== 16'h0030) begin n_err++; $display("FAIL irs_pc %0d: got %h want 0030", i, ir_pc); end
      n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL irs_noreq %0d: got %b want 0", i, mem_req_valid); end
    end
    step_cycle(); ir_ready = 1'b1; @(negedge clk);
    n_cmp++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL irs_accept: got %b want 1", ir_valid); end
    step_cycle(); ir_ready = 1'b0; @(negedge clk);
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL irs_next_req: got %b want 1", mem_req_valid); end
    n_cmp++; if (mem_req_addr !== 16'h0031) begin n_err++; $display("FAIL irs_next_addr: got %h want 0031", mem_req_addr); end
    en = 1'b0;
  endtask

  task automatic test_flush_hold();
    do_reset(16'h0050);
    en = 1'b1; mem_req_ready = 1'b1;
    @(negedge clk); step_cycle(); @(negedge clk); step_cycle(); @(negedge clk);
    step_cycle(); @(negedge clk);
    n_cmp++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL fh_held: got %b want 1", ir_valid); end
    step_cycle(); flush = 1'b1; flush_tgt = 16'h0070; ir_ready = 1'b1; @(negedge clk);
    n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL fh_flush_irv: got %b want 0", ir_valid); end
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL fh_flush_req: got %b want 0", mem_req_valid); end
    step_cycle(); flush = 1'b0; ir_ready = 1'b0; @(negedge clk);
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL fh_new_req: got %b want 1", mem_req_valid); end
    n_cmp++; if (mem_req_addr !== 16'h0070) begin n_err++; $display("FAIL fh_new_addr: got %h want 0070", mem_req_addr); end
    n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL fh_dropped_irv: got %b want 0", ir_valid); end
    en = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    do_reset(16'hFFFF);
    en = 1'b1; mem_req_ready = 1'b1; ir_ready = 1'b1;
    @(negedge clk);
    step_cycle(); @(negedge clk);
    n_cmp++; if (mem_req_addr !== 16'hFFFF) begin n_err++; $display("FAIL wrap_addr: got %h want ffff", mem_req_addr); end
    n_cmp++; if (pc_inc !== 1'b1) begin n_err++; $display("FAIL wrap_inc: got %b want 1", pc_inc); end
    step_cycle(); @(negedge clk);
    step_cycle(); rsp_delay = 6; @(negedge clk);
    n_cmp++; if (ir_pc !== 16'hFFFF) begin n_err++; $display("FAIL wrap_ir_pc: got %h want ffff", ir_pc); end
    n_cmp++; if (ir_data !== memval(16'hFFFF)) begin n_err++; $display("FAIL wrap_ir_data: got %h want %h", ir_data, memval(16'hFFFF)); end
    step_cycle(); @(negedge clk);
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL wrap_next_req: got %b want 1", mem_req_valid); end
    n_cmp++; if (mem_req_addr !== 16'h0000) begin n_err++; $display("FAIL wrap_next_addr: got %h want 0000", mem_req_addr); end
    step_cycle(); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL arst_req: got %b want 0", mem_req_valid); end
    n_cmp++; if (pc_inc !== 1'b0) begin n_err++; $display("FAIL arst_inc: got %b want 0", pc_inc); end
    n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL arst_irv: got %b want 0", ir_valid); end
    n_cmp++; if (ir_data !== 16'h0000) begin n_err++; $display("FAIL arst_ir_data: got %h want 0000", ir_data); end
    n_cmp++; if (ir_pc !== 16'h0000) begin n_err++; $display("FAIL arst_ir_pc: got %h want 0000", ir_pc); end
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_random();
    bit            outst, dropped, held;
    logic [AW-1:0] out_addr, held_pc;
    logic [IW-1:0] held_data;
    int            delivered;
    do_reset(16'($urandom));
    outst = 1'b0; dropped = 1'b0; held = 1'b0; delivered = 0;
    out_addr = '0; held_pc = '0; held_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      en            = ($urandom_range(7) != 0);
      mem_req_ready = ($urandom_range(1) == 1);
      ir_ready      = ($urandom_range(1) == 1);
      flush         = ($urandom_range(15) == 0);
      flush_tgt     = 16'($urandom);
      rsp_delay     = $urandom_range(3, 1);
      @(negedge clk);
      n_cmp++; if (pc_inc !== (mem_req_valid && mem_req_ready)) begin n_err++; $display("FAIL rnd_inc c%0d: got %b want %b", cyc, pc_inc, mem_req_valid && mem_req_ready); end
      if (flush) begin
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rnd_flush_req c%0d: got %b want 0", cyc, mem_req_valid); end
      end
      if (mem_req_valid) begin
        n_cmp++; if (mem_req_addr !== pc) begin n_err++; $display("FAIL rnd_addr c%0d: got %h want %h", cyc, mem_req_addr, pc); end
        n_cmp++; if (outst || held) begin n_err++; $display("FAIL rnd_one_outstanding c%0d: got busy=%b want 0", cyc, outst || held); end
      end
      n_cmp++; if (ir_valid !== (held && !flush)) begin n_err++; $display("FAIL rnd_irv c%0d: got %b want %b", cyc, ir_valid, held && !flush); end
      if (held) begin
        n_cmp++; if (ir_data !== held_data) begin n_err++; $display("FAIL rnd_ir_data c%0d: got %h want %h", cyc, ir_data, held_data); end
        n_cmp++; if (ir_pc !== held_pc) begin n_err++; $display("FAIL rnd_ir_pc c%0d: got %h want %h", cyc, ir_pc, held_pc); end
      end
      // Scoreboard advance for the coming clock edge.
      if (held && (flush || ir_ready)) begin
        if (!flush) delivered++;
        held = 1'b0;
      end
      if (outst && mem_rsp_valid) begin
        outst = 1'b0;
        if (!(dropped || flush)) begin
          held = 1'b1; held_data = memval(out_addr); held_pc = out_addr;
        end
      end else if (outst && flush) begin
        dropped = 1'b1;
      end
      if (mem_req_valid && mem_req_ready) begin
        outst = 1'b1; out_addr = pc; dropped = 1'b0;
      end
      step_cycle();
    end
    flush = 1'b0; en = 1'b0;
    n_cmp++; if (delivered < 100) begin n_err++; $display("FAIL rnd_progress: got %0d delivered want >= 100", delivered); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_req_stall();
    test_flush_wait();
    test_ir_stall();
    test_flush_hold();
    test_wrap_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
